// File: rtl/demux_pkg.sv
// Shared lane count, lane-select type and pointer helper for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SEL_W     = 2;

    typedef logic [SEL_W-1:0] lane_sel_t;

    // Round-robin successor, wrapping 3 -> 0.
    function automatic lane_sel_t next_lane(input lane_sel_t cur);
        return lane_sel_t'(cur + lane_sel_t'(1));
    endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry output holding register with load/drain logic for a single demux lane.
module demux_lane_buf #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    // A load wins over a drain so a simultaneous refill keeps the lane full with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end else if (full && ready) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4.sv
// Registered 1-to-4 valid/ready stream demultiplexer with one holding register per lane.
// Optional feature: define DEMUX_RR_EN to replace in_sel with an internal round-robin pointer.
module demux_1_4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [SEL_W-1:0]              in_sel,
    output logic [NUM_LANES-1:0]          out_valid,
    input  logic [NUM_LANES-1:0]          out_ready,
    output logic [NUM_LANES*DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]              dst_lane
);

    lane_sel_t            target;
    logic                 accept;
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] lane_load;

`ifdef DEMUX_RR_EN
    lane_sel_t rr_ptr;
    logic      sel_unused;

    assign sel_unused = ^in_sel;
    assign target     = rr_ptr;

    // Pointer advances only on an accepted beat; a stalled lane holds it in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= next_lane(rr_ptr);
        end
    end
`else
    assign target = in_sel;
`endif

    assign dst_lane = target;
    assign in_ready = rst_n & (~lane_full[target] | out_ready[target]);
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_load[k] = accept & (target == lane_sel_t'(k));

        demux_lane_buf #(
            .DATA_W (DATA_W)
        ) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (lane_load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .full      (lane_full[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );

        assign out_valid[k] = lane_full[k];
    end

endmodule

// File: tb/tb_demux_1_4.sv
// Scoreboard bench for demux_1_4 (DATA_W=8); per-lane expected queues filled on accept, drained on output.
module tb_demux_1_4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  dst_lane;

    int total = 0;
    int bad   = 0;

    typedef logic [7:0] beat_q_t [$];
    beat_q_t    sb [4];
    logic [1:0] m_ptr = 2'd0;

    demux_1_4 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dst_lane  (dst_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: independent lane-occupancy model checked every falling edge.
    always @(negedge clk) begin
        logic [1:0] ml;
        logic       er;
        logic [7:0] exp_d;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) sb[k].delete();
            m_ptr = 2'd0;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL rst_in_ready got=%b want=0", in_ready);
            end
        end else begin
`ifdef DEMUX_RR_EN
            ml = m_ptr;
`else
            ml = in_sel;
`endif
            er = (sb[ml].size() == 0) || out_ready[ml];
            total++;
            if (in_ready !== er) begin
                bad++;
                $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, er);
            end
            if (in_valid) begin
                total++;
                if (dst_lane !== ml) begin
                    bad++;
                    $display("FAIL dst_lane t=%0t got=%0d want=%0d", $time, dst_lane, ml);
                end
            end
            for (int k = 0; k < 4; k++) begin
                total++;
                if (out_valid[k] !== (sb[k].size() != 0)) begin
                    bad++;
                    $display("FAIL out_valid[%0d] t=%0t got=%b want=%b", k, $time, out_valid[k], sb[k].size() != 0);
                end
                if (sb[k].size() != 0 && out_ready[k]) begin
                    exp_d = sb[k].pop_front();
                    total++;
                    if (out_data[k*8 +: 8] !== exp_d) begin
                        bad++;
                        $display("FAIL lane%0d_data t=%0t got=%h want=%h", k, $time, out_data[k*8 +: 8], exp_d);
                    end
                end
            end
            if (in_valid && er) begin
                sb[ml].push_back(in_data);
                m_ptr = m_ptr + 2'd1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b want=0000", out_valid); end
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", in_ready); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_steer();
        step();
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 2'(i); in_data = 8'hA0 + 8'(i);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL steer_ready[%0d] got=%b want=1", i, in_ready); end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_data[31:24] !== 8'hA3 || out_valid[3] !== 1'b1) begin
            bad++;
            $display("FAIL steer_lane3 got=%b/%h want=1/a3", out_valid[3], out_data[31:24]);
        end
        repeat (2) step();
    endtask

    task automatic test_stall();
        logic [7:0] d [4] = '{8'hB1, 8'hB2, 8'hC2, 8'hC0};
        logic [1:0] s [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
        logic       r [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        out_ready = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = s[i]; in_data = d[i];
            @(negedge clk);
            total++;
            if (in_ready !== r[i]) begin bad++; $display("FAIL stall_ready[%0d] got=%b want=%b", i, in_ready, r[i]); end
            step();
        end
        in_sel = 2'd1; in_data = 8'hB2;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || out_data[15:8] !== 8'hB1) begin
            bad++;
            $display("FAIL stall_hold got=%b/%b/%h want=0/1/b1", in_ready, out_valid[1], out_data[15:8]);
        end
        step();
        out_ready = 4'hF;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_refill got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'hB2) begin
            bad++;
            $display("FAIL stall_second got=%b/%h want=1/b2", out_valid[1], out_data[15:8]);
        end
        repeat (2) step();
    endtask

    task automatic test_midreset();
        out_ready = 4'b0110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hD0;
        step();
        in_sel = 2'd3; in_data = 8'hD3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 4'b1001) begin bad++; $display("FAIL pre_reset_valid got=%b want=1001", out_valid); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL midreset got=%b/%h want=0000/0", out_valid, out_data);
        end
        out_ready = 4'hF;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 4'b0000) begin bad++; $display("FAIL ghost_beat got=%b want=0000", out_valid); end
        end
        step();
    endtask

`ifdef DEMUX_RR_EN
    task automatic test_rr();
        out_ready = 4'hF;
        in_sel = 2'd2;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            @(negedge clk);
            total++;
            if (dst_lane !== 2'(i % 4) || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL rr_beat[%0d] got=%0d/%b want=%0d/1", i, dst_lane, in_ready, i % 4);
            end
            step();
        end
        out_ready = 4'b1101;
        for (int i = 0; i < 7; i++) begin
            in_data = 8'h16 + 8'(i);
            step();
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || dst_lane !== 2'd1) begin
                bad++;
                $display("FAIL rr_stall got=%b/%0d want=0/1", in_ready, dst_lane);
            end
            step();
        end
        out_ready = 4'hF;
        step();
        in_valid = 1'b0;
        repeat (2) step();
    endtask
`endif

    task automatic test_drain();
        int budget;
        in_valid = 1'b0;
        out_ready = 4'hF;
        budget = 50;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && budget > 0) begin
            step();
            budget--;
        end
        total++;
        if (budget == 0) begin bad++; $display("FAIL drain_timeout pending beats remain want=0"); end
    endtask

    initial begin
        test_reset();
        test_steer();
        test_stall();
        test_midreset();
`ifdef DEMUX_RR_EN
        test_rr();
`endif
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
